// File: rtl/radiant_scaler_pulse_conditioner.sv
// Per-channel trigger front end: synchronizer, rising-edge pulse generator with
// programmable holdoff and mask, plus a sticky stuck-high detector.
module radiant_scaler_pulse_conditioner #(
    parameter int NUM_CHANNELS = 32,
    parameter int HOLDOFF_BITS = 8,
    parameter int STUCK_CYCLES = 1023,
    parameter int STUCK_BITS   = $clog2(STUCK_CYCLES + 1)
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [NUM_CHANNELS-1:0] trig_i,
    input  logic [NUM_CHANNELS-1:0] mask_i,
    input  logic [HOLDOFF_BITS-1:0] holdoff_i,
    input  logic                    stuck_clr_i,
    output logic [NUM_CHANNELS-1:0] scal_o,
    output logic [NUM_CHANNELS-1:0] stuck_o,
    output logic                    any_o
);

    typedef enum logic {
        ARMED   = 1'b0,
        HOLDOFF = 1'b1
    } state_t;

    localparam logic [STUCK_BITS-1:0]   STUCK_MAX = STUCK_BITS'(STUCK_CYCLES);
    localparam logic [HOLDOFF_BITS-1:0] HOLD_ONE  = HOLDOFF_BITS'(1);

    logic [NUM_CHANNELS-1:0] sync0;
    logic [NUM_CHANNELS-1:0] sync1;
    logic [NUM_CHANNELS-1:0] prev;
    logic [NUM_CHANNELS-1:0] edge_det;
    logic [NUM_CHANNELS-1:0] accept;
    logic [1:0]              warm_cnt;
    logic                    sync_valid;

    // sync1 only carries real input data two edges after reset release; until
    // then prev stays high so an input already high at release is not an edge.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            warm_cnt <= 2'd0;
        end else if (warm_cnt != 2'd2) begin
            warm_cnt <= warm_cnt + 2'd1;
        end
    end

    assign sync_valid = (warm_cnt == 2'd2);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync0 <= '0;
            sync1 <= '0;
            prev  <= '1;
        end else begin
            sync0 <= trig_i;
            sync1 <= sync0;
            if (sync_valid) begin
                prev <= sync1;
            end
        end
    end

    assign edge_det = sync1 & ~prev;

    for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_chan
        state_t                  state;
        logic [HOLDOFF_BITS-1:0] hold_cnt;
        logic [STUCK_BITS-1:0]   stuck_cnt;
        logic                    stuck_q;

        assign accept[g] = (state == ARMED) && edge_det[g] && !mask_i[g];

        // Edges arriving in HOLDOFF are dropped, not queued.
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                state    <= ARMED;
                hold_cnt <= '0;
            end else begin
                case (state)
                    ARMED: begin
                        if (accept[g] && (holdoff_i != '0)) begin
                            hold_cnt <= holdoff_i;
                            state    <= HOLDOFF;
                        end
                    end
                    HOLDOFF: begin
                        hold_cnt <= hold_cnt - HOLD_ONE;
                        if (hold_cnt == HOLD_ONE) begin
                            state <= ARMED;
                        end
                    end
                    default: begin
                        state <= ARMED;
                    end
                endcase
            end
        end

        // Clear strobe takes priority over a simultaneous set condition.
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                stuck_cnt <= '0;
                stuck_q   <= 1'b0;
            end else if (stuck_clr_i) begin
                stuck_cnt <= '0;
                stuck_q   <= 1'b0;
            end else begin
                if (stuck_cnt == STUCK_MAX) begin
                    stuck_q <= 1'b1;
                end
                if (!sync1[g]) begin
                    stuck_cnt <= '0;
                end else if (stuck_cnt != STUCK_MAX) begin
                    stuck_cnt <= stuck_cnt + STUCK_BITS'(1);
                end
            end
        end

        assign stuck_o[g] = stuck_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            scal_o <= '0;
            any_o  <= 1'b0;
        end else begin
            scal_o <= accept;
            any_o  <= |accept;
        end
    end

endmodule

// File: tb/tb_radiant_scaler_pulse_conditioner.sv
// Scoreboard bench: a per-channel behavioural model predicts scal/any/stuck for
// each driven cycle; the prediction is queued and compared when the DUT updates.
module tb_radiant_scaler_pulse_conditioner;

    localparam int NC = 32;
    localparam int HB = 8;
    localparam int SC = 16;

    typedef struct packed {
        logic [NC-1:0] scal;
        logic          any;
        logic [NC-1:0] stuck;
    } exp_t;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic [NC-1:0] trig_i;
    logic [NC-1:0] mask_i;
    logic [HB-1:0] holdoff_i;
    logic          stuck_clr_i;
    logic [NC-1:0] scal_o;
    logic [NC-1:0] stuck_o;
    logic          any_o;

    radiant_scaler_pulse_conditioner #(
        .NUM_CHANNELS(NC),
        .HOLDOFF_BITS(HB),
        .STUCK_CYCLES(SC)
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .trig_i     (trig_i),
        .mask_i     (mask_i),
        .holdoff_i  (holdoff_i),
        .stuck_clr_i(stuck_clr_i),
        .scal_o     (scal_o),
        .stuck_o    (stuck_o),
        .any_o      (any_o)
    );

    always #10 clk_i = ~clk_i;

    int            checks = 0;
    int            errors = 0;
    exp_t          sb[$];
    int            q;
    logic [NC-1:0] h1, h2, h3;
    int            ready[NC];
    int            scnt[NC];
    logic [NC-1:0] sflag;
    int            pulse_cnt[NC];
    int            first_q[NC];
    int            any_cnt;
    logic [NC-1:0] cur_mask;
    logic [HB-1:0] cur_hold;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("[TB] FAIL %s got %0h expected %0h at %0t", tag, obs, expv, $time);
        end
    endtask

    task automatic modelReset();
        q     = 0;
        h1    = '0;
        h2    = '0;
        h3    = '0;
        sflag = '0;
        for (int c = 0; c < NC; c++) begin
            ready[c] = 0;
            scnt[c]  = 0;
        end
    endtask

    task automatic clearCounts();
        any_cnt = 0;
        for (int c = 0; c < NC; c++) begin
            pulse_cnt[c] = 0;
            first_q[c]   = -1;
        end
    endtask

    // Called at a negedge: drive one cycle, predict, wait one cycle, compare.
    task automatic applyStimulus(input logic [NC-1:0] trig, input logic clr);
        exp_t e;
        exp_t got;
        logic edge_v;
        logic s1_v;
        trig_i      = trig;
        mask_i      = cur_mask;
        holdoff_i   = cur_hold;
        stuck_clr_i = clr;
        q++;
        e.scal = '0;
        for (int c = 0; c < NC; c++) begin
            edge_v = (q >= 4) && h2[c] && !h3[c];
            s1_v   = (q >= 3) && h2[c];
            if (edge_v && !cur_mask[c] && q >= ready[c]) begin
                e.scal[c] = 1'b1;
                if (cur_hold != '0) ready[c] = q + int'(cur_hold) + 1;
            end
            if (clr) begin
                sflag[c] = 1'b0;
                scnt[c]  = 0;
            end else begin
                if (scnt[c] == SC) sflag[c] = 1'b1;
                if (!s1_v) scnt[c] = 0;
                else if (scnt[c] != SC) scnt[c] = scnt[c] + 1;
            end
        end
        h3 = h2;
        h2 = h1;
        h1 = trig;
        e.any   = |e.scal;
        e.stuck = sflag;
        sb.push_back(e);
        @(negedge clk_i);
        if (sb.size() == 0) begin
            checkOutput("sb_empty", 32'd0, 32'd1);
        end else begin
            got = sb.pop_front();
            checkOutput("scal", scal_o, got.scal);
            checkOutput("any", 32'(any_o), 32'(got.any));
            checkOutput("stuck", stuck_o, got.stuck);
        end
        if (any_o) any_cnt++;
        for (int c = 0; c < NC; c++) begin
            if (scal_o[c]) begin
                pulse_cnt[c]++;
                if (first_q[c] < 0) first_q[c] = q;
            end
        end
    endtask

    task automatic doReset(input logic [NC-1:0] trig);
        trig_i      = trig;
        stuck_clr_i = 1'b0;
        rst_i       = 1'b1;
        modelReset();
        repeat (2) @(negedge clk_i);
        checkOutput("rst_scal", scal_o, 32'd0);
        checkOutput("rst_any", 32'(any_o), 32'd0);
        checkOutput("rst_stuck", stuck_o, 32'd0);
        rst_i = 1'b0;
    endtask

    initial begin
        logic [15:0]   pat;
        logic [NC-1:0] tr;
        int            hi_q;
        int            others;
        rst_i       = 1'b1;
        trig_i      = '0;
        mask_i      = '0;
        holdoff_i   = '0;
        stuck_clr_i = 1'b0;
        cur_mask    = '0;
        cur_hold    = '0;
        clearCounts();
        @(negedge clk_i);

        $display("[TB] single edge");
        doReset('0);
        clearCounts();
        repeat (4) applyStimulus('0, 1'b0);
        hi_q = q + 1;
        repeat (10) applyStimulus(32'd1 << 3, 1'b0);
        repeat (10) applyStimulus('0, 1'b0);
        others = 0;
        for (int c = 0; c < NC; c++) if (c != 3) others += pulse_cnt[c];
        checkOutput("single_cnt", 32'(pulse_cnt[3]), 32'd1);
        checkOutput("single_lat", 32'(first_q[3] - hi_q), 32'd2);
        checkOutput("single_any", 32'(any_cnt), 32'd1);
        checkOutput("single_other", 32'(others), 32'd0);

        $display("[TB] holdoff");
        doReset('0);
        cur_hold = 8'd5;
        clearCounts();
        repeat (4) applyStimulus('0, 1'b0);
        pat = 16'b0000_0000_1101_0011;
        for (int i = 0; i < 16; i++) applyStimulus({31'd0, pat[i]}, 1'b0);
        checkOutput("hold5_cnt", 32'(pulse_cnt[0]), 32'd2);
        cur_hold = 8'd0;
        clearCounts();
        repeat (10) begin
            applyStimulus(32'd1, 1'b0);
            applyStimulus('0, 1'b0);
        end
        repeat (4) applyStimulus('0, 1'b0);
        checkOutput("hold0_cnt", 32'(pulse_cnt[0]), 32'd10);

        $display("[TB] mask");
        cur_mask = 32'd1 << 7;
        clearCounts();
        repeat (20) begin
            applyStimulus(32'd1 << 7, 1'b0);
            applyStimulus('0, 1'b0);
        end
        repeat (4) applyStimulus('0, 1'b0);
        checkOutput("mask_cnt", 32'(pulse_cnt[7]), 32'd0);
        cur_mask = '0;
        clearCounts();
        repeat (3) applyStimulus('0, 1'b0);
        repeat (3) applyStimulus(32'd1 << 7, 1'b0);
        repeat (4) applyStimulus('0, 1'b0);
        checkOutput("unmask_cnt", 32'(pulse_cnt[7]), 32'd1);

        $display("[TB] stuck");
        doReset('0);
        repeat (25) applyStimulus(32'd1 << 2, 1'b0);
        checkOutput("stuck_set", 32'(stuck_o[2]), 32'd1);
        repeat (5) applyStimulus('0, 1'b0);
        checkOutput("stuck_hold", 32'(stuck_o[2]), 32'd1);
        applyStimulus('0, 1'b1);
        checkOutput("stuck_clr", 32'(stuck_o[2]), 32'd0);
        repeat (4) applyStimulus(32'd1 << 2, 1'b0);
        applyStimulus(32'd1 << 2, 1'b1);
        repeat (16) applyStimulus(32'd1 << 2, 1'b0);
        applyStimulus(32'd1 << 2, 1'b1);
        checkOutput("stuck_clr_wins", 32'(stuck_o[2]), 32'd0);
        repeat (17) applyStimulus(32'd1 << 2, 1'b0);
        checkOutput("stuck_reflag", 32'(stuck_o[2]), 32'd1);

        $display("[TB] reset with input high");
        doReset(32'd1 << 1);
        cur_hold = 8'd0;
        clearCounts();
        repeat (10) applyStimulus(32'd1 << 1, 1'b0);
        checkOutput("rsthigh_cnt", 32'(pulse_cnt[1]), 32'd0);
        repeat (3) applyStimulus('0, 1'b0);
        repeat (3) applyStimulus(32'd1 << 1, 1'b0);
        repeat (3) applyStimulus('0, 1'b0);
        checkOutput("rsthigh_rise", 32'(pulse_cnt[1]), 32'd1);
        cur_hold = 8'd50;
        clearCounts();
        repeat (3) applyStimulus(32'd1 << 1, 1'b0);
        repeat (5) applyStimulus('0, 1'b0);
        checkOutput("prehold_cnt", 32'(pulse_cnt[1]), 32'd1);
        doReset('0);
        clearCounts();
        repeat (3) applyStimulus('0, 1'b0);
        repeat (3) applyStimulus(32'd1 << 1, 1'b0);
        repeat (3) applyStimulus('0, 1'b0);
        checkOutput("midhold_rst", 32'(pulse_cnt[1]), 32'd1);

        $display("[TB] random");
        doReset('0);
        tr = '0;
        for (int i = 0; i < 800; i++) begin
            if (i % 25 == 0) cur_hold = HB'($urandom_range(0, 12));
            if (i % 60 == 0) cur_mask = $urandom & $urandom & $urandom;
            tr[23:0]  = tr[23:0] ^ 24'($urandom & $urandom);
            tr[31:24] = tr[31:24] ^ 8'($urandom & $urandom & $urandom & $urandom & $urandom);
            applyStimulus(tr, $urandom_range(0, 60) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
